draw_pile: RTL and testbench

DRAW_PILE -- requirements
Module: draw_pile

---
 rtl/draw_pile.sv | 111 +++++++++++
 tb/tb_draw_pile.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_pile.sv
// Card draw pile: captures a shuffled deck, deals the opening hands round robin,
// flips the first non-wild discard, then serves single-card draws.
module draw_pile #(
  parameter int NUM_PLAYERS = 4,
  parameter int HAND_SIZE   = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [5:0] i_deck [107:0],
  input  logic       i_deal_start,
  input  logic       i_draw_req,
  input  logic [1:0] i_draw_player,
  output logic [5:0] o_card,
  output logic       o_card_valid,
  output logic [1:0] o_card_player,
  output logic [5:0] o_start_card,
  output logic       o_start_valid,
  output logic [6:0] o_remaining,
  output logic       o_busy,
  output logic       o_empty,
  output logic       o_err
);
  localparam int         DEAL_N   = NUM_PLAYERS * HAND_SIZE;
  localparam logic [6:0] DEAL_CNT = 7'(DEAL_N);
  localparam logic [6:0] DEAL_MIN = 7'(DEAL_N + 1);
  localparam logic [1:0] LAST_PL  = 2'(NUM_PLAYERS - 1);
  localparam logic [6:0] FULL     = 7'd108;

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_DEAL, S_FLIP} state_t;

  state_t     state;
  logic [5:0] pile [107:0];
  logic [6:0] deal_cnt, cur_cnt;
  logic [1:0] deal_pl, cur_pl;
  logic [5:0] top;
  logic       idle, load_ok, deal_go, deal_fire, draw_ok, flip_hit, flip_dry, err_nxt;

  assign o_busy  = (state == S_DEAL) || (state == S_FLIP);
  assign o_empty = (o_remaining == 7'd0);

  always_comb begin
    idle      = (state == S_EMPTY) || (state == S_READY);
    top       = (o_remaining == 7'd0) ? 6'd0 : pile[o_remaining - 7'd1];
    load_ok   = idle && i_load;
    deal_go   = (state == S_READY) && !i_load && i_deal_start && (o_remaining >= DEAL_MIN);
    deal_fire = deal_go || (state == S_DEAL);
    // the start cycle emits the first card, so counters begin from zero there
    cur_cnt   = (state == S_DEAL) ? deal_cnt : 7'd0;
    cur_pl    = (state == S_DEAL) ? deal_pl : 2'd0;
    draw_ok   = (state == S_READY) && !i_load && !i_deal_start && i_draw_req && (o_remaining != 7'd0);
    flip_hit  = (state == S_FLIP) && (top[3:0] < 4'd13);
    flip_dry  = (state == S_FLIP) && !flip_hit && (o_remaining == 7'd1);
    err_nxt   = flip_dry
             || (o_busy && (i_deal_start || i_draw_req))
             || (idle && !i_load && i_deal_start && !deal_go)
             || (idle && !i_load && !i_deal_start && i_draw_req && !draw_ok);
  end

  // Pile contents carry no reset; they are only meaningful after a load.
  always_ff @(posedge i_clk) begin
    if (!i_rst && load_ok) pile <= i_deck;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_EMPTY;
      o_remaining   <= 7'd0;
      o_card        <= 6'd0;
      o_card_valid  <= 1'b0;
      o_card_player <= 2'd0;
      o_start_card  <= 6'd0;
      o_start_valid <= 1'b0;
      o_err         <= 1'b0;
      deal_cnt      <= 7'd0;
      deal_pl       <= 2'd0;
    end else begin
      o_card_valid  <= 1'b0;
      o_start_valid <= 1'b0;
      o_err         <= err_nxt;
      if (load_ok) begin
        state        <= S_READY;
        o_remaining  <= FULL;
        o_start_card <= 6'd0;
      end else if (deal_fire) begin
        o_card        <= top;
        o_card_player <= cur_pl;
        o_card_valid  <= 1'b1;
        o_remaining   <= o_remaining - 7'd1;
        deal_cnt      <= cur_cnt + 7'd1;
        deal_pl       <= (cur_pl == LAST_PL) ? 2'd0 : cur_pl + 2'd1;
        state         <= (cur_cnt + 7'd1 == DEAL_CNT) ? S_FLIP : S_DEAL;
      end else if (draw_ok) begin
        o_card        <= top;
        o_card_player <= i_draw_player;
        o_card_valid  <= 1'b1;
        o_remaining   <= o_remaining - 7'd1;
      end else if (state == S_FLIP) begin
        // every examined card leaves the pile, burned or not
        o_remaining <= o_remaining - 7'd1;
        if (flip_hit) begin
          o_start_card  <= top;
          o_start_valid <= 1'b1;
          state         <= S_READY;
        end else if (flip_dry) begin
          state <= S_EMPTY;
        end
      end
    end
  end
endmodule

// File: tb/tb_draw_pile.sv
// Bench for draw_pile: vector table, directed deal/flip/draw sequences and
// random traffic checked against a queue-based model of the pile.
module tb_draw_pile;
  localparam int NP = 4;
  localparam int HS = 7;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1, i_load = 1'b0, i_deal_start = 1'b0, i_draw_req = 1'b0;
  logic [1:0] i_draw_player = 2'd0;
  logic [5:0] deck [107:0];
  logic [5:0] o_card, o_start_card;
  logic       o_card_valid, o_start_valid, o_busy, o_empty, o_err;
  logic [1:0] o_card_player;
  logic [6:0] o_remaining;

  always #5 i_clk = ~i_clk;

  draw_pile #(.NUM_PLAYERS(NP), .HAND_SIZE(HS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_deck(deck),
    .i_deal_start(i_deal_start), .i_draw_req(i_draw_req), .i_draw_player(i_draw_player),
    .o_card(o_card), .o_card_valid(o_card_valid), .o_card_player(o_card_player),
    .o_start_card(o_start_card), .o_start_valid(o_start_valid), .o_remaining(o_remaining),
    .o_busy(o_busy), .o_empty(o_empty), .o_err(o_err)
  );

  int checks = 0, failures = 0;
  int n_v = 0, n_err = 0, n_sv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the pile is a queue whose back is the top card.
  int q[$];
  bit m_ready, m_flip, m_v, m_sv, m_err;
  int m_deal_left, m_k, m_card, m_pl, m_start;

  function automatic void deal_one();
    m_card = q.pop_back();
    m_pl   = m_k % NP;
    m_k++;
    m_deal_left--;
    m_v = 1;
    if (m_deal_left == 0) m_flip = 1;
  endfunction

  function automatic void model_step(input bit rst, input bit load, input bit deal,
                                     input bit draw, input int pl);
    int c;
    m_v = 0; m_sv = 0; m_err = 0;
    if (rst) begin
      q.delete(); m_ready = 0; m_deal_left = 0; m_flip = 0;
      m_card = 0; m_pl = 0; m_start = 0;
      return;
    end
    if (m_deal_left > 0 || m_flip) begin
      if (deal || draw) m_err = 1;
      if (m_deal_left > 0) deal_one();
      else begin
        c = q.pop_back();
        if (c % 16 < 13) begin m_start = c; m_sv = 1; m_flip = 0; end
        else if (q.size() == 0) begin m_err = 1; m_flip = 0; m_ready = 0; end
      end
    end else if (load) begin
      q.delete();
      for (int i = 0; i < 108; i++) q.push_back(int'(deck[i]));
      m_ready = 1; m_start = 0;
    end else if (deal) begin
      if (m_ready && q.size() >= NP * HS + 1) begin
        m_deal_left = NP * HS; m_k = 0; deal_one();
      end else m_err = 1;
    end else if (draw) begin
      if (m_ready && q.size() > 0) begin
        m_card = q.pop_back(); m_pl = pl; m_v = 1;
      end else m_err = 1;
    end
  endfunction

  task automatic cycle(input bit rst, input bit load, input bit deal, input bit draw,
                       input logic [1:0] pl);
    i_rst = rst; i_load = load; i_deal_start = deal; i_draw_req = draw; i_draw_player = pl;
    @(posedge i_clk);
    model_step(rst, load, deal, draw, int'(pl));
    #1;
    chk("card_valid", o_card_valid, m_v);
    chk("card", o_card, m_card);
    chk("card_player", o_card_player, m_pl);
    chk("start_valid", o_start_valid, m_sv);
    chk("start_card", o_start_card, m_start);
    chk("err", o_err, m_err);
    chk("remaining", o_remaining, q.size());
    chk("empty", o_empty, q.size() == 0);
    chk("busy", o_busy, (m_deal_left > 0) || m_flip);
    n_v += int'(o_card_valid); n_err += int'(o_err); n_sv += int'(o_start_valid);
  endtask

  task automatic numeric_deck();
    for (int i = 0; i < 108; i++) deck[i] = {2'((i / 10) % 4), 4'(i % 10)};
  endtask

  typedef struct {
    bit rst, load, deal, draw;
    logic [1:0] pl;
    bit e_v;
    logic [5:0] e_card;
    logic [1:0] e_pl;
    bit e_err;
    logic [6:0] e_rem;
    bit e_busy;
  } vec_t;
  vec_t tv [8];

  initial begin
    int s_v, s_err, s_sv, t;
    bit got80;
    tv[0] = '{1, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0,   0};
    tv[1] = '{0, 0, 0, 1, 1, 0, 6'h00, 0, 1, 0,   0};
    tv[2] = '{0, 0, 1, 0, 0, 0, 6'h00, 0, 1, 0,   0};
    tv[3] = '{0, 1, 0, 0, 0, 0, 6'h00, 0, 0, 108, 0};
    tv[4] = '{0, 1, 1, 1, 2, 0, 6'h00, 0, 0, 108, 0};
    tv[5] = '{0, 0, 0, 1, 3, 1, 6'h27, 3, 0, 107, 0};
    tv[6] = '{0, 0, 0, 0, 0, 0, 6'h27, 3, 0, 107, 0};
    tv[7] = '{1, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0,   0};

    numeric_deck();
    for (int i = 0; i < 8; i++) begin
      cycle(tv[i].rst, tv[i].load, tv[i].deal, tv[i].draw, tv[i].pl);
      chk($sformatf("tv%0d_valid", i), o_card_valid, tv[i].e_v);
      chk($sformatf("tv%0d_card", i), o_card, tv[i].e_card);
      chk($sformatf("tv%0d_player", i), o_card_player, tv[i].e_pl);
      chk($sformatf("tv%0d_err", i), o_err, tv[i].e_err);
      chk($sformatf("tv%0d_rem", i), o_remaining, tv[i].e_rem);
      chk($sformatf("tv%0d_busy", i), o_busy, tv[i].e_busy);
    end

    // Deal with two burned wilds before the start card; busy-time requests rejected.
    numeric_deck();
    deck[79] = 6'h3D; deck[78] = 6'h0E; deck[77] = 6'h05;
    cycle(0, 1, 0, 0, 0);
    s_v = n_v; s_err = n_err; s_sv = n_sv; got80 = 0;
    cycle(0, 0, 1, 0, 0);
    chk("first_deal_card", o_card, 6'h27);
    t = 0;
    while (o_busy && t < 60) begin
      cycle(0, 0, t == 4, t == 4, 0);
      if (n_v - s_v == 28 && !got80) begin chk("rem_after_deal", o_remaining, 80); got80 = 1; end
      t++;
    end
    chk("deal_done", o_busy, 0);
    chk("deal_strobes", n_v - s_v, 28);
    chk("busy_errs", n_err - s_err, 1);
    chk("start_strobes", n_sv - s_sv, 1);
    chk("start_card_05", o_start_card, 6'h05);
    chk("rem_77", o_remaining, 77);

    // Drain the pile for player 2, then one draw too many.
    s_v = n_v;
    for (int i = 0; i < 77; i++) cycle(0, 0, 0, 1, 2);
    chk("drain_strobes", n_v - s_v, 77);
    chk("drain_player", o_card_player, 2);
    chk("drain_rem", o_remaining, 0);
    chk("drain_empty", o_empty, 1);
    cycle(0, 0, 0, 1, 2);
    chk("overdraw_err", o_err, 1);
    chk("overdraw_valid", o_card_valid, 0);

    // Reset in the middle of the deal.
    numeric_deck();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0);
    chk("strobe10_player", o_card_player, 1);
    cycle(1, 0, 0, 0, 0);
    chk("rst_valid", o_card_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rem", o_remaining, 0);
    cycle(0, 0, 0, 1, 0);
    chk("post_rst_draw_err", o_err, 1);
    chk("post_rst_rem", o_remaining, 0);
    cycle(0, 0, 1, 0, 0);
    chk("post_rst_deal_err", o_err, 1);

    // Everything below the hands is wild: the flip runs dry.
    numeric_deck();
    for (int i = 0; i < 80; i++) deck[i] = (i % 2 == 0) ? 6'h0D : 6'h2E;
    cycle(0, 1, 0, 0, 0);
    s_err = n_err; s_sv = n_sv;
    cycle(0, 0, 1, 0, 0);
    t = 0;
    while (o_busy && t < 200) begin cycle(0, 0, 0, 0, 0); t++; end
    chk("dry_done", o_busy, 0);
    chk("dry_err", n_err - s_err, 1);
    chk("dry_no_start", n_sv - s_sv, 0);
    chk("dry_rem", o_remaining, 0);
    cycle(0, 0, 1, 0, 0);
    chk("dry_deal_err", o_err, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, l, d, w;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 19) == 0);
      w = ($urandom_range(0, 9) < 4);
      if (l) for (int j = 0; j < 108; j++) deck[j] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 14))};
      cycle(r, l, d, w, 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
